// File: rtl/regfile_pkg.sv
// Shared constants for the 16x16 register file: word width, register count,
// index width and the hardwired-zero register index.
package regfile_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 16;
  localparam int IDX_W    = 4;

  localparam logic [IDX_W-1:0] R0_IDX = 4'd0;

  typedef logic [IDX_W-1:0] reg_idx_t;

endpackage : regfile_pkg

// File: rtl/reg_word.sv
// One register word: WIDTH flops with synchronous clear (rst wins over write)
// and a write enable driven by the top-level write wordline.
module reg_word
  import regfile_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] word_d;

  always_comb begin
    word_d = word_q;
    if (wr_en) begin
      word_d = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign rd_data = word_q;

endmodule : reg_word

// File: rtl/register_file_16x16.sv
// 16-entry register file, one write port and two combinational read ports, R0 reads zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a matching read port.
module register_file_16x16 #(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WriteReg,
  input  logic [3:0]        DstReg,
  input  logic [DATA_W-1:0] DstData,
  input  logic [3:0]        SrcReg1,
  input  logic [3:0]        SrcReg2,
  output logic [DATA_W-1:0] SrcData1,
  output logic [DATA_W-1:0] SrcData2
);

  localparam int                            IDX_W   = regfile_pkg::IDX_W;
  localparam logic [IDX_W-1:0]              R0_IDX  = regfile_pkg::R0_IDX;
  localparam logic [NUM_REGS-1:0]           R0_MASK = NUM_REGS'(1) << R0_IDX;

  logic [NUM_REGS-1:0] wr_wl;
  logic [NUM_REGS-1:0] rd1_wl;
  logic [NUM_REGS-1:0] rd2_wl;
  logic [NUM_REGS-1:0] rd1_sel;
  logic [NUM_REGS-1:0] rd2_sel;
  logic [DATA_W-1:0]   word_val [NUM_REGS];
  logic [DATA_W-1:0]   stored1;
  logic [DATA_W-1:0]   stored2;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_word
      // R0 never receives a write wordline, so its storage stays at the reset value.
      assign wr_wl[gi]  = WriteReg && (DstReg == IDX_W'(gi)) && (IDX_W'(gi) != R0_IDX);
      assign rd1_wl[gi] = (SrcReg1 == IDX_W'(gi));
      assign rd2_wl[gi] = (SrcReg2 == IDX_W'(gi));

      reg_word #(
        .WIDTH (DATA_W)
      ) u_word (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_wl[gi]),
        .wr_data (DstData),
        .rd_data (word_val[gi])
      );
    end
  endgenerate

  // Masking the R0 read wordline keeps R0 reads at zero even before the first reset.
  assign rd1_sel = rd1_wl & ~R0_MASK;
  assign rd2_sel = rd2_wl & ~R0_MASK;

  always_comb begin
    stored1 = '0;
    stored2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd1_sel[i]) begin
        stored1 = stored1 | word_val[i];
      end
      if (rd2_sel[i]) begin
        stored2 = stored2 | word_val[i];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic byp1;
  logic byp2;

  assign byp1 = WriteReg && !rst && (DstReg == SrcReg1) && (DstReg != R0_IDX);
  assign byp2 = WriteReg && !rst && (DstReg == SrcReg2) && (DstReg != R0_IDX);

  assign SrcData1 = byp1 ? DstData : stored1;
  assign SrcData2 = byp2 ? DstData : stored2;
`else
  assign SrcData1 = stored1;
  assign SrcData2 = stored2;
`endif

endmodule : register_file_16x16

// File: tb/tb_register_file_16x16.sv
// Self-checking bench: directed vector table, full write/read sweep and
// randomized traffic against an array-based reference model.
module tb_register_file_16x16;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        WriteReg;
  logic [3:0]  DstReg;
  logic [15:0] DstData;
  logic [3:0]  SrcReg1;
  logic [3:0]  SrcReg2;
  logic [15:0] SrcData1;
  logic [15:0] SrcData2;

  register_file_16x16 dut (
    .clk      (clk),
    .rst      (rst),
    .WriteReg (WriteReg),
    .DstReg   (DstReg),
    .DstData  (DstData),
    .SrcReg1  (SrcReg1),
    .SrcReg2  (SrcReg2),
    .SrcData1 (SrcData1),
    .SrcData2 (SrcData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference contents: plain array, R0 entry is never written.
  logic [15:0] mem [16];

  typedef struct {
    bit          r;
    bit          we;
    logic [3:0]  dst;
    logic [15:0] data;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [15:0] e1;
    logic [15:0] e2;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [15:0] model_read(input logic [3:0] idx, input bit r, input bit we,
                                             input logic [3:0] dst, input logic [15:0] data);
    if (idx == 4'd0) return 16'h0000;
    if (BYP && we && !r && dst == idx) return data;
    return mem[idx];
  endfunction

  // One cycle: drive at negedge, check reads mid-cycle, then commit to the model at posedge.
  task automatic step(input string name, input bit r, input bit we, input logic [3:0] dst,
                      input logic [15:0] data, input logic [3:0] s1, input logic [3:0] s2,
                      input logic [15:0] e1, input logic [15:0] e2);
    @(negedge clk);
    rst = r; WriteReg = we; DstReg = dst; DstData = data; SrcReg1 = s1; SrcReg2 = s2;
    #2;
    $display("%s rst=%0b we=%0b dst=%0d data=%h s1=%0d s2=%0d -> %h %h",
             name, r, we, dst, data, s1, s2, SrcData1, SrcData2);
    check({name, ".p1"}, SrcData1, e1);
    check({name, ".p2"}, SrcData2, e2);
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 16; k++) mem[k] = 16'h0000;
    end else if (we && dst != 4'd0) begin
      mem[dst] = data;
    end
  endtask

  initial begin
    logic [15:0] haz;
    logic [15:0] haz3;
    haz  = BYP ? 16'hA5A5 : 16'h0001;
    haz3 = BYP ? 16'hFFFF : 16'h0000;

    vecs[0]  = '{0, 1, 4'd5, 16'hBEEF, 4'd0, 4'd0, 16'h0000, 16'h0000};
    vecs[1]  = '{0, 0, 4'd0, 16'h0000, 4'd5, 4'd5, 16'hBEEF, 16'hBEEF};
    vecs[2]  = '{0, 1, 4'd0, 16'h1234, 4'd5, 4'd0, 16'hBEEF, 16'h0000};
    vecs[3]  = '{0, 0, 4'd0, 16'h0000, 4'd0, 4'd5, 16'h0000, 16'hBEEF};
    vecs[4]  = '{0, 1, 4'd7, 16'h0001, 4'd0, 4'd0, 16'h0000, 16'h0000};
    vecs[5]  = '{0, 1, 4'd7, 16'hA5A5, 4'd7, 4'd5, haz,      16'hBEEF};
    vecs[6]  = '{0, 0, 4'd0, 16'h0000, 4'd7, 4'd7, 16'hA5A5, 16'hA5A5};
    vecs[7]  = '{0, 1, 4'd3, 16'hFFFF, 4'd3, 4'd3, haz3,     haz3};
    vecs[8]  = '{0, 0, 4'd0, 16'h0000, 4'd3, 4'd0, 16'hFFFF, 16'h0000};
    vecs[9]  = '{1, 1, 4'd3, 16'hFFFF, 4'd3, 4'd7, 16'hFFFF, 16'hA5A5};
    vecs[10] = '{0, 0, 4'd0, 16'h0000, 4'd3, 4'd7, 16'h0000, 16'h0000};
    vecs[11] = '{0, 0, 4'd0, 16'h0000, 4'd5, 4'd5, 16'h0000, 16'h0000};

    for (int k = 0; k < 16; k++) mem[k] = 16'h0000;

    rst = 1'b1; WriteReg = 1'b0; DstReg = 4'd0; DstData = 16'h0000;
    SrcReg1 = 4'd0; SrcReg2 = 4'd0;
    @(posedge clk);

    // Every index reads zero right after a single reset cycle.
    for (int i = 0; i < 16; i++) begin
      step("reset_read", 0, 0, 4'd0, 16'h0000, 4'(i), 4'(15 - i), 16'h0000, 16'h0000);
    end

    for (int i = 0; i < 12; i++) begin
      step($sformatf("vec%0d", i), vecs[i].r, vecs[i].we, vecs[i].dst, vecs[i].data,
           vecs[i].s1, vecs[i].s2, vecs[i].e1, vecs[i].e2);
    end

    // Sweep: Rn = n*0x1111, then every read pair.
    for (int n = 1; n < 16; n++) begin
      step("sweep_wr", 0, 1, 4'(n), 16'(n * 16'h1111), 4'd0, 4'd0, 16'h0000, 16'h0000);
    end
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        step("sweep_rd", 0, 0, 4'd0, 16'h0000, 4'(i), 4'(j),
             16'(i * 16'h1111), 16'(j * 16'h1111));
      end
    end

    // Randomized traffic with occasional resets.
    for (int t = 0; t < 400; t++) begin
      bit          r, we;
      logic [3:0]  dst, s1, s2;
      logic [15:0] data;
      r    = ($urandom_range(0, 31) == 0);
      we   = $urandom_range(0, 1);
      dst  = 4'($urandom_range(0, 15));
      data = 16'($urandom);
      s1   = ($urandom_range(0, 3) == 0) ? dst : 4'($urandom_range(0, 15));
      s2   = ($urandom_range(0, 3) == 0) ? dst : 4'($urandom_range(0, 15));
      step("rand", r, we, dst, data, s1, s2,
           model_read(s1, r, we, dst, data), model_read(s2, r, we, dst, data));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_register_file_16x16
